// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Package : clk_div_pkg
// Brief   : Shared mode encodings and default divider constant for prog_clk_div
// Rev     : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam logic        MODE_FREE    = 1'b0;
    localparam logic        MODE_ONESHOT = 1'b1;

    // Terminal value giving the legacy LED rate: y[0] toggles every 2^25 clocks
    localparam int unsigned DIV_1HZ_LED  = 32'd33554431;

endpackage
`default_nettype wire

// File: rtl/prog_clk_div_if.sv
`default_nettype none
// ============================================================================
// Interface : prog_clk_div_if
// Brief     : Control and status bundle of the programmable clock divider
// Rev       : 1.0  initial release
// ============================================================================
interface prog_clk_div_if #(
    parameter int CNT_W   = 28,
    parameter int NUM_OUT = 3
);
    logic               en;
    logic               clr;
    logic               mode;
    logic               start;
    logic               div_load;
    logic [CNT_W-1:0]   div_val;
    logic               tick;
    logic [NUM_OUT-1:0] y;
    logic [CNT_W-1:0]   cnt;
    logic               busy;

    modport master (
        output en, clr, mode, start, div_load, div_val,
        input  tick, y, cnt, busy
    );

    modport slave (
        input  en, clr, mode, start, div_load, div_val,
        output tick, y, cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/prog_clk_div_prescaler.sv
`default_nettype none
// ============================================================================
// Module : tick_prescaler
// Brief  : Prescaler counter with shadowed, wrap-synchronous divider reload
// Rev    : 1.0  initial release
// ============================================================================
module tick_prescaler
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = 28,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_1HZ_LED)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_run,
    input  wire logic             i_zero,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_div_val,
    output logic                  o_wrap,
    output logic [CNT_W-1:0]      o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shadow;
    logic             r_pend;
    logic             w_wrap;
    logic             w_apply;

    // >= rather than == so a count held above a newly shrunk divider wraps at once
    assign w_wrap  = i_run && !i_zero && (r_cnt >= r_div_act);
    assign w_apply = w_wrap || !i_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_div_act    <= DEFAULT_DIV;
            r_div_shadow <= DEFAULT_DIV;
            r_pend       <= 1'b0;
        end else begin
            if (i_zero || w_wrap) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (i_load) begin
                r_div_shadow <= i_div_val;
            end

            // A load in a wrap/idle cycle bypasses the shadow and takes effect now
            if (w_apply) begin
                if (i_load) begin
                    r_div_act <= i_div_val;
                end else if (r_pend) begin
                    r_div_act <= r_div_shadow;
                end
                r_pend <= 1'b0;
            end else if (i_load) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_wrap = w_wrap;
    assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module : prog_clk_div
// Brief  : Programmable tick generator with free-run/one-shot modes and y counter
// Rev    : 1.0  initial release
// ============================================================================
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = 28,
    parameter int               NUM_OUT     = 3,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_1HZ_LED)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    prog_clk_div_if.slave  bus
);

    logic               r_run;
    logic               r_tick;
    logic [NUM_OUT-1:0] r_y;
    logic               w_running;
    logic               w_arm;
    logic               w_wrap;
    logic [CNT_W-1:0]   w_cnt;

    assign w_running = bus.en && ((bus.mode == MODE_FREE) || r_run);
    assign w_arm     = (bus.mode == MODE_ONESHOT) && bus.start && !r_run && !bus.clr;

    tick_prescaler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_running),
        .i_zero    (bus.clr || w_arm),
        .i_load    (bus.div_load),
        .i_div_val (bus.div_val),
        .o_wrap    (w_wrap),
        .o_cnt     (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_tick <= 1'b0;
            r_y    <= '0;
        end else if (bus.clr) begin
            r_run  <= 1'b0;
            r_tick <= 1'b0;
            r_y    <= '0;
        end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
                r_y <= r_y + 1'b1;
            end
            // Leaving one-shot mode abandons any run; a one-shot ends on its own wrap
            if (bus.mode == MODE_FREE) begin
                r_run <= 1'b0;
            end else if (w_arm) begin
                r_run <= 1'b1;
            end else if (w_wrap) begin
                r_run <= 1'b0;
            end
        end
    end

    assign bus.tick = r_tick;
    assign bus.y    = r_y;
    assign bus.cnt  = w_cnt;
    assign bus.busy = (bus.mode == MODE_FREE) ? bus.en : r_run;

endmodule
`default_nettype wire
